// File: rtl/uart_wb_master.sv
// Serial-to-Wishbone debug bridge: parses 'W'/'R' byte commands from the UART,
// runs one 32-bit Wishbone master cycle, and replies 'K' (+read data) or 'E'.

module uart #(
   parameter int unsigned clk_freq = 100000000,
   parameter int unsigned baud     = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic       txd,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   output logic       rx_error,
   input  logic       rx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_busy
);
   localparam int unsigned DIV = clk_freq / baud;
   localparam int unsigned CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

   logic [2:0]    rx_sync_q, rx_sync_d;
   logic          rx_busy_q, rx_busy_d, rx_avail_q, rx_avail_d, rx_error_q, rx_error_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic [3:0]    rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic          tx_busy_q, tx_busy_d, txd_q, txd_d;
   logic [9:0]    tx_sh_q, tx_sh_d;
   logic          rxs, rxp;

   assign rxs = rx_sync_q[1];
   assign rxp = rx_sync_q[2];

   always_comb begin
      rx_sync_d  = {rx_sync_q[1:0], rxd};
      rx_busy_d  = rx_busy_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_avail_d = rx_avail_q;
      rx_error_d = rx_error_q;
      if (rx_ack) rx_avail_d = 1'b0;
      // Start only on a falling edge so a low line after a framing error is not re-read.
      if (!rx_busy_q) begin
         if (rxp && !rxs) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = HALF;
            rx_bit_d  = 4'd0;
         end
      end else if (rx_cnt_q != '0) begin
         rx_cnt_d = rx_cnt_q - 1'b1;
      end else begin
         rx_cnt_d = FULL;
         if (rx_bit_q == 4'd0) begin
            if (rxs) rx_busy_d = 1'b0;
            else     rx_bit_d  = 4'd1;
         end else if (rx_bit_q == 4'd9) begin
            rx_busy_d  = 1'b0;
            rx_data_d  = rx_sh_q;
            rx_avail_d = 1'b1;
            rx_error_d = !rxs;
         end else begin
            rx_sh_d  = {rxs, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 4'd1;
         end
      end
   end

   always_comb begin
      tx_busy_d = tx_busy_q;
      tx_cnt_d  = tx_cnt_q;
      tx_bit_d  = tx_bit_q;
      tx_sh_d   = tx_sh_q;
      if (!tx_busy_q) begin
         if (tx_wr) begin
            tx_sh_d   = {1'b1, tx_data, 1'b0};
            tx_busy_d = 1'b1;
            tx_cnt_d  = FULL;
            tx_bit_d  = 4'd0;
         end
      end else if (tx_cnt_q != '0) begin
         tx_cnt_d = tx_cnt_q - 1'b1;
      end else begin
         tx_cnt_d = FULL;
         tx_sh_d  = {1'b1, tx_sh_q[9:1]};
         if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
         else                  tx_bit_d  = tx_bit_q + 4'd1;
      end
      txd_d = tx_busy_d ? tx_sh_d[0] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync_q  <= '1;
         rx_busy_q  <= 1'b0;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_avail_q <= 1'b0;
         rx_error_q <= 1'b0;
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '1;
         txd_q      <= 1'b1;
      end else begin
         rx_sync_q  <= rx_sync_d;
         rx_busy_q  <= rx_busy_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_avail_q <= rx_avail_d;
         rx_error_q <= rx_error_d;
         tx_busy_q  <= tx_busy_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         txd_q      <= txd_d;
      end
   end

   assign txd      = txd_q;
   assign rx_data  = rx_data_q;
   assign rx_avail = rx_avail_q;
   assign rx_error = rx_error_q;
   assign tx_busy  = tx_busy_q;
endmodule

module uart_wb_master #(
   parameter int unsigned clk_freq = 100000000,
   parameter int unsigned baud     = 115200,
   parameter int unsigned timeout  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        uart_rxd,
   output logic        uart_txd
);
   localparam int unsigned TW = (timeout > 2) ? $clog2(timeout) : 1;
   localparam logic [TW-1:0] TLAST = TW'(timeout - 1);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic          we_q, we_d, err_q, err_d, hdr_q, hdr_d, cyc_q, cyc_d;
   logic          rx_ack_q, rx_ack_d, tx_wr_q, tx_wr_d;
   logic [31:0]   adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [7:0]    rx_data;
   logic          rx_avail, rx_error, tx_busy, take;

   uart #(.clk_freq(clk_freq), .baud(baud)) u_uart (
      .clk(clk), .reset(reset), .rxd(uart_rxd), .txd(uart_txd),
      .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack_q),
      .tx_data(tx_data_q), .tx_wr(tx_wr_q), .tx_busy(tx_busy)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      we_d      = we_q;
      err_d     = err_q;
      hdr_d     = hdr_q;
      cyc_d     = cyc_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      rdat_d    = rdat_q;
      tx_data_d = tx_data_q;
      cnt_d     = cnt_q;
      rx_ack_d  = 1'b0;
      tx_wr_d   = 1'b0;
      // rx_ack is registered, so rx_avail is still high the cycle after a take.
      take      = rx_avail && !rx_ack_q;
      case (state_q)
         IDLE: if (take) begin
            rx_ack_d = 1'b1;
            idx_d    = 2'd0;
            if (!rx_error && (rx_data == 8'h57 || rx_data == 8'h52)) begin
               we_d    = (rx_data == 8'h57);
               state_d = ADDR;
            end
         end
         ADDR, DATA: if (take) begin
            rx_ack_d = 1'b1;
            if (rx_error) begin
               state_d = IDLE;
            end else begin
               if (state_q == ADDR) adr_d = {adr_q[23:0], rx_data};
               else                 dat_d = {dat_q[23:0], rx_data};
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  if (state_q == ADDR && we_q) begin
                     state_d = DATA;
                  end else begin
                     state_d = BUS;
                     cyc_d   = 1'b1;
                     cnt_d   = '0;
                  end
               end
            end
         end
         BUS: begin
            if (wb_ack_i || cnt_q == TLAST) begin
               if (wb_ack_i) rdat_d = wb_dat_i;
               err_d   = !wb_ack_i;
               cyc_d   = 1'b0;
               hdr_d   = 1'b1;
               idx_d   = 2'd0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: if (!tx_busy && !tx_wr_q) begin
            tx_wr_d = 1'b1;
            if (hdr_q) begin
               hdr_d     = 1'b0;
               tx_data_d = err_q ? 8'h45 : 8'h4B;
               if (err_q || we_q) state_d = IDLE;
            end else begin
               tx_data_d = rdat_q[31:24];
               rdat_d    = {rdat_q[23:0], 8'h00};
               idx_d     = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         hdr_q     <= 1'b0;
         cyc_q     <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         rdat_q    <= '0;
         tx_data_q <= '0;
         cnt_q     <= '0;
         rx_ack_q  <= 1'b0;
         tx_wr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         err_q     <= err_d;
         hdr_q     <= hdr_d;
         cyc_q     <= cyc_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rdat_q    <= rdat_d;
         tx_data_q <= tx_data_d;
         cnt_q     <= cnt_d;
         rx_ack_q  <= rx_ack_d;
         tx_wr_q   <= tx_wr_d;
      end
   end

   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = 4'hF;
endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: serial host model, Wishbone slave model and
// scoreboards for expected bus cycles and reply bytes.

module tb_uart_wb_master;
   localparam int unsigned CLK_FREQ = 800;
   localparam int unsigned BAUD     = 100;
   localparam int unsigned TMO      = 16;
   localparam int unsigned BIT      = CLK_FREQ / BAUD;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        uart_rxd, uart_txd;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      int          waits;
      logic        ack;
      logic [31:0] rdata;
      int          len;
   } bus_t;

   bus_t       bus_q[$];
   logic [7:0] exp_q[$];
   int         checks   = 0;
   int         failures = 0;

   uart_wb_master #(.clk_freq(CLK_FREQ), .baud(BAUD), .timeout(TMO)) dut (
      .clk(clk), .reset(reset),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .uart_rxd(uart_rxd), .uart_txd(uart_txd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad);
      uart_rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      uart_rxd = !bad;
      repeat (BIT) @(negedge clk);
      if (bad) begin
         uart_rxd = 1'b1;
         repeat (2 * BIT) @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0);
   endtask

   task automatic send_write(input logic [31:0] adr, input logic [31:0] dat, input int waits);
      bus_q.push_back('{we: 1'b1, adr: adr, dat: dat, waits: waits, ack: 1'b1, rdata: 32'h0, len: waits + 1});
      exp_q.push_back(8'h4B);
      send_byte(8'h57, 1'b0);
      send_word(adr);
      send_word(dat);
   endtask

   task automatic send_read(input logic [31:0] adr, input int waits, input logic ack, input logic [31:0] rdata);
      bus_q.push_back('{we: 1'b0, adr: adr, dat: 32'h0, waits: waits, ack: ack, rdata: rdata,
                        len: ack ? waits + 1 : int'(TMO)});
      if (ack) begin
         exp_q.push_back(8'h4B);
         for (int i = 3; i >= 0; i--) exp_q.push_back(rdata[8*i +: 8]);
      end else begin
         exp_q.push_back(8'h45);
      end
      send_byte(8'h52, 1'b0);
      send_word(adr);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 6000) begin
         @(negedge clk);
         n++;
      end
      repeat (BIT * 12) @(negedge clk);
      check("drain_reply", exp_q.size(), 0);
      check("drain_bus", bus_q.size(), 0);
   endtask

   // Reply decoder: samples mid-bit on uart_txd and pops the reply scoreboard.
   logic [7:0] txb;
   always begin
      @(negedge uart_txd);
      if (!reset) begin
         repeat (BIT / 2) @(posedge clk);
         #1 check("tx_start", uart_txd, 0);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(posedge clk);
            #1 txb[i] = uart_txd;
         end
         repeat (BIT) @(posedge clk);
         #1 check("tx_stop", uart_txd, 1);
         check("reply_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("reply_byte", txb, exp_q.pop_front());
      end
   end

   // Slave model: pops an expected cycle on cyc rise, acks after the given waits.
   bus_t cur;
   logic in_cyc  = 1'b0;
   int   cyc_len = 0;
   always @(negedge clk) begin
      if (wb_cyc_o === 1'b1) begin
         if (!in_cyc) begin
            check("bus_pending", bus_q.size() > 0, 1);
            if (bus_q.size() > 0) cur = bus_q.pop_front();
            else cur = '{we: 1'b0, adr: 32'h0, dat: 32'h0, waits: 0, ack: 1'b1, rdata: 32'h0, len: -1};
            in_cyc  = 1'b1;
            cyc_len = 0;
         end
         check("stb", wb_stb_o, 1);
         check("we", wb_we_o, cur.we);
         check("adr", wb_adr_o, cur.adr);
         check("sel", wb_sel_o, 4'hF);
         if (cur.we) check("wdat", wb_dat_o, cur.dat);
         wb_ack_i = cur.ack && (cyc_len == cur.waits);
         wb_dat_i = wb_ack_i ? cur.rdata : ~cur.rdata;
         cyc_len++;
      end else begin
         wb_ack_i = 1'b0;
         if (in_cyc) begin
            in_cyc = 1'b0;
            if (cur.len > 0) check("cyc_len", cyc_len, cur.len);
         end
      end
   end

   initial begin
      uart_rxd = 1'b1;
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      reset    = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_cyc", wb_cyc_o, 0);
      check("rst_stb", wb_stb_o, 0);
      check("rst_we", wb_we_o, 0);
      check("rst_adr", wb_adr_o, 0);
      check("rst_dat", wb_dat_o, 0);
      check("rst_sel", wb_sel_o, 4'hF);
      check("rst_txd", uart_txd, 1);
      reset = 1'b0;
      repeat (2 * BIT) @(negedge clk);

      send_write(32'h00001004, 32'hDEADBEEF, 0);
      drain();
      send_read(32'h00002000, 3, 1'b1, 32'h12345678);
      drain();
      send_read(32'hABCD0010, 0, 1'b0, 32'h0);
      drain();
      send_read(32'h00000100, int'(TMO) - 1, 1'b1, 32'h0BADCAFE);
      drain();

      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_read(32'h00000008, 0, 1'b1, 32'hCAFEF00D);
      drain();

      send_byte(8'h57, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b1);
      send_write(32'h00000040, 32'h01020304, 1);
      drain();

      bus_q.push_back('{we: 1'b0, adr: 32'h00000080, dat: 32'h0, waits: 0, ack: 1'b0, rdata: 32'h0, len: -1});
      send_byte(8'h52, 1'b0);
      send_word(32'h00000080);
      for (int i = 0; i < 200 && wb_cyc_o !== 1'b1; i++) @(negedge clk);
      check("rst_cyc_up", wb_cyc_o, 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_cyc", wb_cyc_o, 0);
      check("midrst_stb", wb_stb_o, 0);
      check("midrst_adr", wb_adr_o, 0);
      reset = 1'b0;
      drain();
      send_write(32'h00000200, 32'hA5A55A5A, 2);
      drain();

      send_write(32'h00003000, 32'h11223344, 0);
      send_write(32'h00003004, 32'h55667788, 2);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
